// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter_if
// Purpose  : Bundles the two writeback request channels and the regfile
//            write port of regfile_wr_arbiter.
// Ports    : v0/a0/d0/r0  req0 (ALU writeback) valid/addr/data/ready
//            v1/a1/d1/r1  req1 (load writeback) valid/addr/data/ready
//            wen/wadd/wdata  registered regfile write port
//            busy         arbiter is holding the grant for req1
//            grant_cnt    saturating count of writes that reached the regfile
// Modports : slave  - the arbiter
//            master - the writeback stage / regfile side
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          v0;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0;
  logic          r0;
  logic          v1;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1;
  logic          r1;
  logic          wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] wdata;
  logic          busy;
  logic [7:0]    grant_cnt;

  modport slave (
    input  v0, a0, d0, v1, a1, d1,
    output r0, r1, wen, wadd, wdata, busy, grant_cnt
  );

  modport master (
    output v0, a0, d0, v1, a1, d1,
    input  r0, r1, wen, wadd, wdata, busy, grant_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Shares the single regfile write port between req0 (ALU
//            writeback) and req1 (load writeback). Fixed priority to req0
//            with a burst limit so a pending req1 is served after at most
//            MAX_BURST consecutive req0 grants. Writes to register 0 are
//            acknowledged but never reach the regfile.
// Ports    : clk          rising-edge clock
//            rst          synchronous, active-low reset
//            bus          regfile_wr_arbiter_if.slave (requests + write port)
//            Optional (macro RF_BYPASS_EN defined):
//            ra1, ra2     read addresses
//            rf_rd1/2     raw regfile read data
//            fwd_rd1/2    read data forwarded from the pending write
// Params   : AW (address width), DW (data width), MAX_BURST (1..15)
// Revision : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_wr_arbiter_if.slave bus
`ifdef RF_BYPASS_EN
  ,
  input  wire logic [AW-1:0] ra1,
  input  wire logic [AW-1:0] ra2,
  input  wire logic [DW-1:0] rf_rd1,
  input  wire logic [DW-1:0] rf_rd2,
  output logic      [DW-1:0] fwd_rd1,
  output logic      [DW-1:0] fwd_rd2
`endif
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    LOCK1  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [3:0]    w_cnt_inc;
  logic          w_g0;
  logic          w_g1;
  logic          w_xfer;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  logic          r_wen;
  logic [AW-1:0] r_wadd;
  logic [DW-1:0] r_wdata;
  logic [7:0]    r_gcnt;

  assign w_cnt_inc = r_cnt + 4'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant / next-state logic. IDLE and BURST0 apply the same priority rule;
  // they differ only in that the burst counter is known to be zero in IDLE.
  // Grants are suppressed while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    if (rst) begin
      case (r_state)
        LOCK1: begin
          // One shot for req1; if it has withdrawn, nothing is granted.
          w_g1        = bus.v1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
        IDLE, BURST0: begin
          if (bus.v0) begin
            w_g0 = 1'b1;
            if (bus.v1) begin
              // req1 is waiting: this req0 grant counts toward the limit.
              if (w_cnt_inc == c_max_burst) begin
                w_state_nxt = LOCK1;
                w_cnt_nxt   = 4'd0;
              end else begin
                w_state_nxt = BURST0;
                w_cnt_nxt   = w_cnt_inc;
              end
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 4'd0;
            end
          end else begin
            w_g1        = bus.v1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign bus.r0 = w_g0;
  assign bus.r1 = w_g1;
  assign bus.busy = (r_state == LOCK1);

  assign w_xfer = w_g0 | w_g1;
  assign w_addr = w_g0 ? bus.a0 : bus.a1;
  assign w_data = w_g0 ? bus.d0 : bus.d1;

  // --------------------------------------------------------------------------
  // Registered write port. A register-0 transfer still updates wadd/wdata
  // (the slot is consumed) but never raises wen or bumps grant_cnt.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_wadd  <= '0;
      r_wdata <= '0;
      r_gcnt  <= 8'd0;
    end else begin
      r_wen <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_wadd  <= w_addr;
        r_wdata <= w_data;
      end
      if (w_xfer && (w_addr != '0) && (r_gcnt != 8'hFF)) begin
        r_gcnt <= r_gcnt + 8'd1;
      end
    end
  end

  assign bus.wen       = r_wen;
  assign bus.wadd      = r_wadd;
  assign bus.wdata     = r_wdata;
  assign bus.grant_cnt = r_gcnt;

`ifdef RF_BYPASS_EN
  // Forward the write sitting in the output register, which the regfile has
  // not captured yet; register 0 is never forwarded.
  assign fwd_rd1 = (r_wen && (r_wadd == ra1) && (ra1 != '0)) ? r_wdata : rf_rd1;
  assign fwd_rd2 = (r_wen && (r_wadd == ra2) && (ra2 != '0)) ? r_wdata : rf_rd2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Self-checking bench for regfile_wr_arbiter. Directed sequences
//            with literal expectations, then randomized traffic compared
//            every cycle against a behavioural model.
// Ports    : none (top-level bench)
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wr_arbiter;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef RF_BYPASS_EN
  logic [AW-1:0] ra1 = '0, ra2 = '0;
  logic [DW-1:0] rf_rd1 = '0, rf_rd2 = '0;
  logic [DW-1:0] fwd_rd1, fwd_rd2;
`endif

  regfile_wr_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef RF_BYPASS_EN
    ,
    .ra1     (ra1),
    .ra2     (ra2),
    .rf_rd1  (rf_rd1),
    .rf_rd2  (rf_rd2),
    .fwd_rd1 (fwd_rd1),
    .fwd_rd2 (fwd_rd2)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: state after the most recent clock edge.
  // --------------------------------------------------------------------------
  logic          m_wen   = 1'b0;
  logic [AW-1:0] m_wadd  = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_gcnt  = 0;
  int            m_run   = 0;     // req0 grants taken while req1 waited
  bit            m_lock  = 1'b0;  // req1 owed its turn this cycle

  always @(negedge clk) begin
    bit e0, e1;
    logic [AW-1:0] ad;
    chk("wen", bus.wen, m_wen);
    chk("wadd", bus.wadd, m_wadd);
    chk("wdata", bus.wdata, m_wdata);
    chk("grant_cnt", bus.grant_cnt, m_gcnt);
    chk("busy", bus.busy, m_lock);
`ifdef RF_BYPASS_EN
    chk("fwd_rd1", fwd_rd1, (m_wen && m_wadd == ra1 && ra1 != 0) ? m_wdata : rf_rd1);
    chk("fwd_rd2", fwd_rd2, (m_wen && m_wadd == ra2 && ra2 != 0) ? m_wdata : rf_rd2);
`endif
    e0 = 0; e1 = 0;
    if (rst) begin
      if (m_lock) e1 = bus.v1;
      else if (bus.v0) e0 = 1;
      else e1 = bus.v1;
    end
    chk("r0", bus.r0, e0);
    chk("r1", bus.r1, e1);
    if (!rst) begin
      m_wen = 0; m_wadd = '0; m_wdata = '0; m_gcnt = 0; m_run = 0; m_lock = 0;
    end else begin
      if (e0 || e1) begin
        ad      = e0 ? bus.a0 : bus.a1;
        m_wadd  = ad;
        m_wdata = e0 ? bus.d0 : bus.d1;
        m_wen   = (ad != 0);
        if (ad != 0 && m_gcnt < 255) m_gcnt++;
      end else begin
        m_wen = 0;
      end
      if (m_lock) begin
        m_lock = 0;
      end else if (bus.v0 && bus.v1) begin
        m_run++;
        if (m_run == MAX) begin
          m_lock = 1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 4) == 0) return '0;
    return AW'($urandom);
  endfunction

  initial begin
    logic [7:0] g;
    bit x0, x1;
    bus.v0 = 1; bus.a0 = 5'd1; bus.d0 = 32'd4;
    bus.v1 = 0; bus.a1 = '0;   bus.d1 = '0;

    // Reset held: no ready, outputs cleared.
    repeat (3) begin
      @(negedge clk);
      chk("rst_r0", bus.r0, 0);
      chk("rst_wen", bus.wen, 0);
      chk("rst_wadd", bus.wadd, 0);
      chk("rst_gcnt", bus.grant_cnt, 0);
    end
    tick();
    rst = 1;
    @(negedge clk);
    chk("rel_r0", bus.r0, 1);
    tick();
    bus.v0 = 0;
    bus.v1 = 1; bus.a1 = 5'd2; bus.d1 = 32'h11;
`ifdef RF_BYPASS_EN
    ra1 = 5'd1; rf_rd1 = 32'd0; ra2 = 5'd0; rf_rd2 = 32'h55;
`endif
    @(negedge clk);
    chk("rel_wen", bus.wen, 1);
    chk("rel_wadd", bus.wadd, 1);
    chk("rel_wdata", bus.wdata, 4);
`ifdef RF_BYPASS_EN
    chk("byp_fwd1", fwd_rd1, 32'd4);
    chk("byp_fwd2", fwd_rd2, 32'h55);
`endif

    // Single requester stream on req1.
    chk("str_r1", bus.r1, 1);
    tick();
    bus.a1 = 5'd3; bus.d1 = 32'h22;
    @(negedge clk);
    chk("str_wadd0", bus.wadd, 2);
    chk("str_wdata0", bus.wdata, 32'h11);
    tick();
    bus.a1 = 5'd4; bus.d1 = 32'h33;
    @(negedge clk);
    chk("str_wadd1", bus.wadd, 3);
    chk("str_wdata1", bus.wdata, 32'h22);
    tick();
    bus.v1 = 0;
    @(negedge clk);
    chk("str_wen2", bus.wen, 1);
    chk("str_wadd2", bus.wadd, 4);
    chk("str_wdata2", bus.wdata, 32'h33);
    chk("str_gcnt", bus.grant_cnt, 4);  // 1 from the reset test + 3
    tick();

    // Contention: req1 wins exactly every 5th cycle.
    bus.v0 = 1; bus.a0 = 5'd6; bus.d0 = 32'hA;
    bus.v1 = 1; bus.a1 = 5'd7; bus.d1 = 32'hB;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("cont_r1", bus.r1, (i % 5) == 4);
      chk("cont_r0", bus.r0, (i % 5) != 4);
      tick();
    end
    bus.v0 = 0; bus.v1 = 0;
    tick();

    // Register-0 suppression.
    bus.v0 = 1; bus.a0 = 5'd0; bus.d0 = 32'd1;
    @(negedge clk);
    chk("z_r0", bus.r0, 1);
    g = bus.grant_cnt;
    tick();
    bus.a0 = 5'd31; bus.d0 = 32'd7;
    @(negedge clk);
    chk("z_wen", bus.wen, 0);
    chk("z_gcnt", bus.grant_cnt, g);
    tick();
    bus.v0 = 0;
    @(negedge clk);
    chk("z31_wen", bus.wen, 1);
    chk("z31_wadd", bus.wadd, 31);
    chk("z31_wdata", bus.wdata, 7);
    chk("z31_gcnt", bus.grant_cnt, g + 8'd1);
    tick();

    // Reset in the cycle after a transfer to register 5.
    bus.v0 = 1; bus.a0 = 5'd5; bus.d0 = 32'd9;
    bus.v1 = 1; bus.a1 = 5'd8; bus.d1 = 32'd3;
    @(negedge clk);
    chk("mr_r0", bus.r0, 1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mr_wen_pre", bus.wen, 1);
    chk("mr_wadd_pre", bus.wadd, 5);
    chk("mr_r0_rst", bus.r0, 0);
    chk("mr_r1_rst", bus.r1, 0);
    tick();
    @(negedge clk);
    chk("mr_wen", bus.wen, 0);
    chk("mr_busy", bus.busy, 0);
    tick();
    rst = 1;
    @(negedge clk);
    chk("mr_first_r0", bus.r0, 1);
    chk("mr_first_r1", bus.r1, 0);
    tick();
    bus.v0 = 0; bus.v1 = 0;

    // Randomized traffic; requesters hold addr/data while waiting and may
    // occasionally withdraw. Resets only early so grant_cnt can saturate.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      x0 = bus.v0 && bus.r0;
      x1 = bus.v1 && bus.r1;
      tick();
      rst = (i >= 1000) || ($urandom_range(0, 199) != 0);
      if (bus.v0 && !x0) begin
        if ($urandom_range(0, 15) == 0) bus.v0 = 0;
      end else begin
        bus.v0 = ($urandom_range(0, 99) < 65);
        bus.a0 = rnd_addr();
        bus.d0 = $urandom;
      end
      if (bus.v1 && !x1) begin
        if ($urandom_range(0, 15) == 0) bus.v1 = 0;
      end else begin
        bus.v1 = ($urandom_range(0, 99) < 65);
        bus.a1 = rnd_addr();
        bus.d1 = $urandom;
      end
`ifdef RF_BYPASS_EN
      ra1 = AW'($urandom_range(0, 3));
      ra2 = AW'($urandom_range(0, 3));
      rf_rd1 = $urandom;
      rf_rd2 = $urandom;
`endif
    end
    @(negedge clk);
    chk("sat_gcnt", bus.grant_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single regfile write port (wen/wadd/wdata) between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Arbitration is fixed-priority toward req0, with a burst limit so req1 cannot starve.
- Each request uses a valid/ready handshake.
- Writes to register $0 are accepted but never reach the regfile.
- Sits between the writeback stage and the regfile.

Parameters:
- AW, 5, register address width.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive req0 grants while req1 is pending; range 1..15.

Ports:
- clk  in  1  system clock; every flop updates on the rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-low.
- v0  in  1  req0 valid.
- a0  in  AW  req0 destination register.
- d0  in  DW  req0 write data.
- r0  out  1  req0 ready (combinational).
- v1  in  1  req1 valid.
- a1  in  AW  req1 destination register.
- d1  in  DW  req1 write data.
- r1  out  1  req1 ready (combinational).
- wen  out  1  regfile write enable (registered).
- wadd  out  AW  regfile write address (registered).
- wdata  out  DW  regfile write data (registered).
- busy  out  1  high when the arbiter is in LOCK1.
- grant_cnt  out  8  count of accepted writes that went to the regfile; saturates at 255.

Behaviour:
- Reset (rst==0 at posedge):
  - wen=0, wadd=0, wdata=0, grant_cnt=0, burst counter=0, FSM=IDLE.
  - r0 and r1 are forced 0 for as long as rst is low.
- Handshake:
  - A transfer occurs in a cycle where vX && rX are both high.
  - rX is never high unless vX is high.
  - r0 and r1 are never high in the same cycle.
  - A requester must hold aX/dX stable while vX is high and rX is low.
- Latency:
  - A transfer in cycle N drives wen/wadd/wdata at edge N+1; the regfile captures the write at edge N+2.
  - Sustained throughput is one write per cycle.
- Output register:
  - Each cycle, wen <= transfer && (addr != 0).
  - wadd/wdata <= granted addr/data on a transfer; otherwise they hold their previous value.
- FSM states and transitions:
  - IDLE: no valid requests. If only one vX is high, grant it. If both are high, grant req0 and go to BURST0.
  - BURST0: req0 is granted while v0 is high. The burst counter increments on each req0 grant taken while v1 is high.
    - When the counter reaches MAX_BURST and v1 is high, the next grant goes to req1: r1=1, r0=0, counter cleared, go to LOCK1.
    - If v1 drops, clear the counter and return to IDLE-equivalent priority.
  - LOCK1: req1 holds the grant for exactly one transfer, then return to IDLE. If v1 drops before its transfer, return to IDLE without granting.
  - v0 alone in any state: grant req0; the counter is unaffected unless v1 is high.
- $0 writes:
  - The transfer is acknowledged (rX=1) and consumes its slot, but wen stays 0.
  - grant_cnt does not increment.
- grant_cnt: +1 per transfer with a nonzero address; holds at 255.
- Reset mid-operation:
  - A transfer in flight is dropped.
  - wen falls at the reset edge, with no partial write.
  - The counter and FSM clear.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined, these ports are added:
  - ra1, ra2  in  AW  read addresses.
  - rf_rd1, rf_rd2  in  DW  raw regfile read data.
  - fwd_rd1, fwd_rd2  out  DW  forwarded read data.
- Forwarding rule: fwd_rdX = (wen && wadd==raX && raX!=0) ? wdata : rf_rdX. This is combinational and closes the write-to-read hazard for the pending write.
- When not defined, these ports are absent, and readers use the regfile outputs directly with a one-cycle write-to-read gap.

Test Plan:
- Reset: hold rst=0 for 3 cycles with v0=1, a0=1, d0=4 → r0=0, wen=0, wadd=0, grant_cnt=0. Release rst → r0=1 in the first cycle; wen=1, wadd=1, wdata=4 at the next edge.
- Single requester stream: v1=1 with a1=2,3,4 and d1=0x11,0x22,0x33 on consecutive cycles → wen high for 3 cycles with matching wadd/wdata; grant_cnt=3.
- Contention, MAX_BURST=4: v0 and v1 held high → r0 high for 4 cycles, then r1 for 1 cycle, repeating; req1 is granted exactly every 5th cycle.
- $0 suppression: v0=1, a0=0, d0=1 → r0=1, wen stays 0, grant_cnt unchanged. A following write a0=31, d0=7 → wen=1, wadd=31, wdata=7.
- Mid-burst reset: assert rst=0 in the cycle after a transfer to a0=5 → wen=0 at that edge, FSM back in IDLE, and the next contention starts with req0.
- RF_BYPASS_EN: with wen=1, wadd=1, wdata=3, set ra1=1, rf_rd1=0 → fwd_rd1=3. Set ra2=0 → fwd_rd2=rf_rd2.
